// File: rtl/ram2_arb_pkg.sv
// Shared types and helpers for the dual-port ram2 arbiter.
package ram2_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WR      = 2'd1,
    ST_RD_CMD  = 2'd2,
    ST_RD_DATA = 2'd3
  } port_state_e;

  localparam int unsigned READ_LATENCY = 3;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram2_port_seq.sv
// Single ram2 port sequencer: registered RAM controls, read-owner tracking
// and a read-return pulse in the cycle the RAM's registered data is valid.
module ram2_port_seq
  import ram2_arb_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned IDX_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  issue,
  input  logic                  issue_we,
  input  logic [ADDR_WIDTH-1:0] issue_addr,
  input  logic [DATA_WIDTH-1:0] issue_wdata,
  input  logic [IDX_WIDTH-1:0]  issue_owner,
  output logic                  free_c,
  output logic                  ret_c,
  output logic [IDX_WIDTH-1:0]  ret_owner_c,
  output logic [DATA_WIDTH-1:0] ret_data_c,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  port_state_e           state, state_nxt;
  logic                  cs_nxt, we_nxt, oe_nxt;
  logic [ADDR_WIDTH-1:0] addr_nxt;
  logic [DATA_WIDTH-1:0] wdata_nxt;
  logic [IDX_WIDTH-1:0]  owner, owner_nxt;

  // RD_CMD is the only state in which the port cannot accept a new command.
  assign free_c      = (state != ST_RD_CMD);
  assign ret_c       = (state == ST_RD_DATA);
  assign ret_owner_c = owner;
  assign ret_data_c  = ram_rdata;

  always_comb begin
    state_nxt = ST_IDLE;
    cs_nxt    = 1'b0;
    we_nxt    = 1'b0;
    oe_nxt    = 1'b0;
    addr_nxt  = '0;
    wdata_nxt = '0;
    owner_nxt = owner;
    case (state)
      ST_RD_CMD: begin
        state_nxt = ST_RD_DATA;
        cs_nxt    = 1'b1;
        oe_nxt    = 1'b1;
        addr_nxt  = ram_addr;
      end
      default: begin
        if (issue) begin
          cs_nxt    = 1'b1;
          addr_nxt  = issue_addr;
          owner_nxt = issue_owner;
          if (issue_we) begin
            state_nxt = ST_WR;
            we_nxt    = 1'b1;
            wdata_nxt = issue_wdata;
          end else begin
            state_nxt = ST_RD_CMD;
            oe_nxt    = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      ram_cs    <= 1'b0;
      ram_we    <= 1'b0;
      ram_oe    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      owner     <= '0;
    end else begin
      state     <= state_nxt;
      ram_cs    <= cs_nxt;
      ram_we    <= we_nxt;
      ram_oe    <= oe_nxt;
      ram_addr  <= addr_nxt;
      ram_wdata <= wdata_nxt;
      owner     <= owner_nxt;
    end
  end

endmodule

// File: rtl/ram2_arbiter.sv
// Round-robin arbiter sharing the two ram2 ports between NREQ requesters,
// with at most one write per cycle and per-requester read-data return.
module ram2_arbiter
  import ram2_arb_pkg::*;
#(
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_we,
  input  logic [NREQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NREQ-1:0]            gnt,
  output logic [NREQ-1:0]            rvalid,
  output logic [NREQ*DATA_WIDTH-1:0] rdata,
  output logic                       ram_cs0,
  output logic                       ram_we0,
  output logic                       ram_oe0,
  output logic [ADDR_WIDTH-1:0]      ram_addr0,
  output logic [DATA_WIDTH-1:0]      ram_wdata0,
  input  logic [DATA_WIDTH-1:0]      ram_rdata0,
  output logic                       ram_cs1,
  output logic                       ram_we1,
  output logic                       ram_oe1,
  output logic [ADDR_WIDTH-1:0]      ram_addr1,
  output logic [DATA_WIDTH-1:0]      ram_wdata1,
  input  logic [DATA_WIDTH-1:0]      ram_rdata1
);

  localparam int unsigned IW = idx_width(NREQ);

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return IW'((32'(i) + 32'd1) % NREQ);
  endfunction

  logic [IW-1:0]         ptr;
  logic [NREQ-1:0]       busy, elig, busy_set, busy_clr;
  logic                  free0_c, free1_c, pick0, pick1;
  logic [IW-1:0]         idx0, idx1, cand, start1;
  logic                  ret0_c, ret1_c;
  logic [IW-1:0]         ret_owner0_c, ret_owner1_c;
  logic [DATA_WIDTH-1:0] ret_data0_c, ret_data1_c;

  // A requester with a read in flight sits out until its data returns.
  assign elig = req & ~busy & {NREQ{~rst}};

  // Port 0 searches from ptr; port 1 continues after port 0's winner.
  always_comb begin
    pick0  = 1'b0;
    idx0   = '0;
    pick1  = 1'b0;
    idx1   = '0;
    cand   = '0;
    start1 = ptr;
    gnt    = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(ptr) + i) % NREQ);
      if (!pick0 && free0_c && elig[cand]) begin
        pick0 = 1'b1;
        idx0  = cand;
      end
    end
    if (pick0) start1 = wrap_inc(idx0);
    for (int unsigned i = 0; i < NREQ; i++) begin
      cand = IW'((32'(start1) + i) % NREQ);
      if (!pick1 && free1_c && elig[cand] &&
          !(pick0 && (cand == idx0 || (req_we[idx0] && req_we[cand])))) begin
        pick1 = 1'b1;
        idx1  = cand;
      end
    end
    if (pick0) gnt[idx0] = 1'b1;
    if (pick1) gnt[idx1] = 1'b1;
  end

  always_comb begin
    busy_set = '0;
    busy_clr = '0;
    if (pick0 && !req_we[idx0]) busy_set[idx0] = 1'b1;
    if (pick1 && !req_we[idx1]) busy_set[idx1] = 1'b1;
    if (ret0_c) busy_clr[ret_owner0_c] = 1'b1;
    if (ret1_c) busy_clr[ret_owner1_c] = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr    <= '0;
      busy   <= '0;
      rvalid <= '0;
      rdata  <= '0;
    end else begin
      busy   <= (busy & ~busy_clr) | busy_set;
      rvalid <= busy_clr;
      if (ret0_c) rdata[DATA_WIDTH*32'(ret_owner0_c) +: DATA_WIDTH] <= ret_data0_c;
      if (ret1_c) rdata[DATA_WIDTH*32'(ret_owner1_c) +: DATA_WIDTH] <= ret_data1_c;
      if (pick0 || pick1) ptr <= wrap_inc(pick1 ? idx1 : idx0);
    end
  end

  ram2_port_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (IW)
  ) u_port0 (
    .clk         (clk),
    .rst         (rst),
    .issue       (pick0),
    .issue_we    (req_we[idx0]),
    .issue_addr  (req_addr[ADDR_WIDTH*32'(idx0) +: ADDR_WIDTH]),
    .issue_wdata (req_wdata[DATA_WIDTH*32'(idx0) +: DATA_WIDTH]),
    .issue_owner (idx0),
    .free_c      (free0_c),
    .ret_c       (ret0_c),
    .ret_owner_c (ret_owner0_c),
    .ret_data_c  (ret_data0_c),
    .ram_cs      (ram_cs0),
    .ram_we      (ram_we0),
    .ram_oe      (ram_oe0),
    .ram_addr    (ram_addr0),
    .ram_wdata   (ram_wdata0),
    .ram_rdata   (ram_rdata0)
  );

  ram2_port_seq #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .IDX_WIDTH  (IW)
  ) u_port1 (
    .clk         (clk),
    .rst         (rst),
    .issue       (pick1),
    .issue_we    (req_we[idx1]),
    .issue_addr  (req_addr[ADDR_WIDTH*32'(idx1) +: ADDR_WIDTH]),
    .issue_wdata (req_wdata[DATA_WIDTH*32'(idx1) +: DATA_WIDTH]),
    .issue_owner (idx1),
    .free_c      (free1_c),
    .ret_c       (ret1_c),
    .ret_owner_c (ret_owner1_c),
    .ret_data_c  (ret_data1_c),
    .ram_cs      (ram_cs1),
    .ram_we      (ram_we1),
    .ram_oe      (ram_oe1),
    .ram_addr    (ram_addr1),
    .ram_wdata   (ram_wdata1),
    .ram_rdata   (ram_rdata1)
  );

endmodule

// File: tb/tb_ram2_arbiter.sv
// Self-checking bench for ram2_arbiter: behavioural ram2 memory, a
// transaction-level expectation model, and directed scenarios.
module tb_ram2_arbiter;
  import ram2_arb_pkg::*;

  localparam int unsigned NREQ = 4;
  localparam int unsigned DW   = 8;
  localparam int unsigned AW   = 8;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req, req_we;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      gnt, rvalid;
  logic [NREQ*DW-1:0]   rdata;
  logic                 ram_cs0, ram_we0, ram_oe0, ram_cs1, ram_we1, ram_oe1;
  logic [AW-1:0]        ram_addr0, ram_addr1;
  logic [DW-1:0]        ram_wdata0, ram_wdata1, ram_rdata0, ram_rdata1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ram2_arbiter #(.NREQ(NREQ), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_we(req_we), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .ram_cs0(ram_cs0), .ram_we0(ram_we0), .ram_oe0(ram_oe0), .ram_addr0(ram_addr0),
    .ram_wdata0(ram_wdata0), .ram_rdata0(ram_rdata0),
    .ram_cs1(ram_cs1), .ram_we1(ram_we1), .ram_oe1(ram_oe1), .ram_addr1(ram_addr1),
    .ram_wdata1(ram_wdata1), .ram_rdata1(ram_rdata1)
  );

  // ram2 behaviour: registered reads, port-1 write dropped when port 0 writes.
  logic [DW-1:0] mem [256];
  always @(posedge clk) begin
    if (ram_cs0 && ram_we0) mem[ram_addr0] <= ram_wdata0;
    else if (ram_cs1 && ram_we1) mem[ram_addr1] <= ram_wdata1;
    if (ram_cs0 && ram_oe0 && !ram_we0) ram_rdata0 <= mem[ram_addr0];
    if (ram_cs1 && ram_oe1 && !ram_we1) ram_rdata1 <= mem[ram_addr1];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- expectation model ----------------
  typedef struct {
    int            due;
    int            who;
    logic [DW-1:0] data;
  } ret_t;
  typedef struct packed {
    logic          cs;
    logic          we;
    logic          oe;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } cmd_t;

  ret_t          pend[$];
  cmd_t          cur[2], nxt[2];
  int            free_at[2];
  int            m_ptr, cyc;
  logic [DW-1:0] m_rdata[NREQ];
  logic [DW-1:0] refmem[256];
  logic [NREQ-1:0]    e_gnt, e_rv, m_elig;
  logic [NREQ*DW-1:0] e_rd;
  int            win[2];
  int            st, ka;
  bit            inflight;

  initial begin
    m_ptr = 0; cyc = 0;
    for (int p = 0; p < 2; p++) begin cur[p] = '0; nxt[p] = '0; free_at[p] = 0; end
    for (int k = 0; k < NREQ; k++) m_rdata[k] = '0;
  end

  always @(negedge clk) begin
    e_rv = '0;
    for (int k = 0; k < NREQ; k++) e_rd[k*DW +: DW] = m_rdata[k];
    foreach (pend[i]) if (pend[i].due == cyc) begin
      e_rv[pend[i].who] = 1'b1;
      e_rd[pend[i].who*DW +: DW] = pend[i].data;
    end
    for (int k = 0; k < NREQ; k++) begin
      inflight = 1'b0;
      foreach (pend[i]) if (pend[i].who == k && pend[i].due > cyc) inflight = 1'b1;
      m_elig[k] = req[k] && !inflight && !rst;
    end
    win[0] = -1; win[1] = -1;
    if (cyc >= free_at[0])
      for (int i = 0; i < NREQ; i++)
        if (win[0] < 0 && m_elig[(m_ptr + i) % NREQ]) win[0] = (m_ptr + i) % NREQ;
    st = (win[0] >= 0) ? (win[0] + 1) % NREQ : m_ptr;
    if (cyc >= free_at[1])
      for (int i = 0; i < NREQ; i++) begin
        ka = (st + i) % NREQ;
        if (win[1] < 0 && m_elig[ka] && ka != win[0] &&
            !(win[0] >= 0 && req_we[win[0]] && req_we[ka])) win[1] = ka;
      end
    e_gnt = '0;
    for (int p = 0; p < 2; p++) if (win[p] >= 0) e_gnt[win[p]] = 1'b1;

    check("gnt", 32'(gnt), 32'(e_gnt));
    check("rvalid", 32'(rvalid), 32'(e_rv));
    check("rdata", 32'(rdata), 32'(e_rd));
    check("port0", 32'({ram_cs0, ram_we0, ram_oe0, ram_addr0, ram_wdata0}), 32'(cur[0]));
    check("port1", 32'({ram_cs1, ram_we1, ram_oe1, ram_addr1, ram_wdata1}), 32'(cur[1]));
    check("dual_write", 32'(ram_we0 && ram_we1), 32'd0);

    if (rst) begin
      pend.delete();
      m_ptr = 0;
      for (int p = 0; p < 2; p++) begin cur[p] = '0; nxt[p] = '0; free_at[p] = 0; end
      for (int k = 0; k < NREQ; k++) m_rdata[k] = '0;
    end else begin
      for (int k = 0; k < NREQ; k++) m_rdata[k] = e_rd[k*DW +: DW];
      for (int i = pend.size() - 1; i >= 0; i--) if (pend[i].due <= cyc) pend.delete(i);
      for (int p = 0; p < 2; p++) begin cur[p] = nxt[p]; nxt[p] = '0; end
      for (int p = 0; p < 2; p++) if (win[p] >= 0) begin
        ka = win[p];
        if (req_we[ka]) begin
          cur[p] = '{1'b1, 1'b1, 1'b0, req_addr[ka*AW +: AW], req_wdata[ka*DW +: DW]};
        end else begin
          cur[p] = '{1'b1, 1'b0, 1'b1, req_addr[ka*AW +: AW], '0};
          nxt[p] = cur[p];
          free_at[p] = cyc + 2;
          pend.push_back('{cyc + int'(READ_LATENCY), ka, refmem[req_addr[ka*AW +: AW]]});
        end
      end
      // Same-cycle writes land after the read snapshot above.
      for (int p = 0; p < 2; p++)
        if (win[p] >= 0 && req_we[win[p]])
          refmem[req_addr[win[p]*AW +: AW]] = req_wdata[win[p]*DW +: DW];
      if (win[1] >= 0) m_ptr = (win[1] + 1) % NREQ;
      else if (win[0] >= 0) m_ptr = (win[0] + 1) % NREQ;
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  logic [NREQ-1:0] glog[$];
  int              gcount[NREQ];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step(1);
    rst = 1'b0;
  endtask

  // Each masked requester issues its operation reps times, re-requesting right after each grant.
  task automatic run(input logic [NREQ-1:0] m, input logic [NREQ-1:0] we,
                     input logic [NREQ*AW-1:0] a, input logic [NREQ*DW-1:0] d, input int reps);
    int left[NREQ];
    int n, rem;
    logic [NREQ-1:0] g;
    glog.delete();
    for (int k = 0; k < NREQ; k++) begin left[k] = m[k] ? reps : 0; gcount[k] = 0; end
    req_we = we; req_addr = a; req_wdata = d; req = m;
    n = 0;
    forever begin
      rem = 0;
      for (int k = 0; k < NREQ; k++) rem += left[k];
      if (rem == 0) break;
      if (n >= 100) begin
        n_cmp++; n_bad++;
        $display("FAIL run_timeout: %0d grants outstanding after %0d cycles", rem, n);
        req = '0;
        break;
      end
      @(negedge clk);
      g = gnt;
      step(1);
      glog.push_back(g);
      n++;
      for (int k = 0; k < NREQ; k++)
        if (g[k] && left[k] > 0) begin
          left[k]--; gcount[k]++;
          if (left[k] == 0) req[k] = 1'b0;
        end
    end
  endtask

  function automatic logic [NREQ-1:0] glog_at(input int i);
    return (i < glog.size()) ? glog[i] : '0;
  endfunction

  // Called in the cycle after the read grant.
  task automatic expect_read(input int k, input logic [DW-1:0] v);
    repeat (2) begin
      @(negedge clk);
      check("rvalid_early", 32'(rvalid), 32'd0);
    end
    @(negedge clk);
    check("rvalid_lat3", 32'(rvalid), 32'd1 << k);
    check("rdata_val", 32'(rdata[k*DW +: DW]), 32'(v));
    step(1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    step(3);
    rst = 1'b0;

    // Write then read back through requester 0.
    run(4'b0001, 4'b0001, 32'h0000_0010, 32'h0000_00A5, 1);
    check("wr0_gnt", 32'(glog_at(0)), 32'h1);
    run(4'b0001, 4'b0000, 32'h0000_0010, 32'h0, 1);
    check("rd0_gnt", 32'(glog_at(0)), 32'h1);
    expect_read(0, 8'hA5);
    step(2);

    // Four simultaneous writers serialise one per cycle.
    do_reset();
    run(4'b1111, 4'b1111, 32'h2322_2120, 32'h4342_4140, 1);
    check("wr_all_len", glog.size(), 4);
    for (int i = 0; i < 4; i++) check($sformatf("wr_order%0d", i), 32'(glog_at(i)), 32'd1 << i);
    step(2);

    // Write and read of the same address in one cycle: read sees old data.
    run(4'b0010, 4'b0010, 32'h0000_3000, 32'h0000_1100, 1);
    step(2);
    do_reset();
    run(4'b0110, 4'b0010, 32'h0030_3000, 32'h0000_2200, 1);
    check("wr_rd_gnt", 32'(glog_at(0)), 32'h6);
    expect_read(2, 8'h11);
    run(4'b0100, 4'b0000, 32'h0030_0000, 32'h0, 1);
    expect_read(2, 8'h22);
    step(2);

    // Continuous reads from all four requesters.
    do_reset();
    run(4'b1111, 4'b0000, 32'h2322_2120, 32'h0, 2);
    check("rd_all_len", glog.size(), 7);
    for (int i = 0; i < 7; i++)
      check($sformatf("rd_pat%0d", i), 32'(glog_at(i)),
            (i % 2 == 1) ? 32'h0 : ((i % 4 == 0) ? 32'h3 : 32'hC));
    for (int k = 0; k < NREQ; k++) check($sformatf("rd_cnt%0d", k), gcount[k], 2);
    step(6);

    // Reset aborts an outstanding read; request during reset is ignored.
    do_reset();
    run(4'b0100, 4'b0000, 32'h0021_0000, 32'h0, 1);
    check("abort_gnt", 32'(glog_at(0)), 32'h4);
    rst = 1'b1;
    req = 4'b1000; req_we = '0; req_addr = 32'h2300_0000;
    step(1);
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    check("post_rst_ctl", 32'({ram_cs0, ram_we0, ram_oe0, ram_cs1, ram_we1, ram_oe1}), 32'd0);
    check("post_rst_bus", 32'({ram_addr0, ram_addr1, ram_wdata0, ram_wdata1}), 32'd0);
    check("post_rst_out", 32'({gnt, rvalid}), 32'd0);
    check("post_rst_rdata", 32'(rdata), 32'd0);
    step(1);
    @(negedge clk);
    check("abort_no_rvalid", 32'(rvalid), 32'd0);
    step(1);
    run(4'b1010, 4'b0000, 32'h2300_2200, 32'h0, 1);
    check("first_gnt", 32'(glog_at(0)), 32'hA);
    @(negedge clk);
    check("first_port0", 32'(ram_addr0), 32'h22);
    check("first_port1", 32'(ram_addr1), 32'h23);
    step(6);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
